// File: rtl/reg_share_arbiter.sv
// Round-robin arbiter in front of a shared WIDTH-bit register.
// The granted requester's word is captured into a held output (reg_d)
// that feeds the register's data_in. After each grant the arbiter stays
// busy for one GRANT cycle plus HOLD_CYCLES hold cycles, so reg_d is
// stable for at least that long before the next grant can replace it.
module reg_share_arbiter #(
  parameter int WIDTH       = 8,
  parameter int NREQ        = 4,
  parameter int HOLD_CYCLES = 2,
  parameter int IDXW        = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] wdata,
  output logic [NREQ-1:0]       gnt,
  output logic [WIDTH-1:0]      reg_d,
  output logic                  reg_valid,
  output logic [IDXW-1:0]       owner,
  output logic                  busy
);

  // Hold counter is wide enough for HOLD_CYCLES-1, never narrower than 1 bit.
  localparam int CNTW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
  localparam logic [CNTW-1:0] HOLD_LOAD = (HOLD_CYCLES > 0) ? CNTW'(HOLD_CYCLES - 1) : '0;
  localparam logic [IDXW-1:0] LAST_IDX  = IDXW'(NREQ - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [WIDTH-1:0]  hold_word_q, hold_word_d;
  logic              valid_q, valid_d;
  logic [IDXW-1:0]   owner_q, owner_d;
  logic              busy_q, busy_d;
  logic [IDXW-1:0]   ptr_q, ptr_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;

  logic [WIDTH-1:0]  word [NREQ];
  logic              found;
  logic [IDXW-1:0]   win_idx;

  // Unpack the flattened requester words into an indexable array.
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign word[gi] = wdata[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Rotating priority search: first set req bit starting at ptr, wrapping
  // modulo NREQ (explicit subtract so non-power-of-two NREQ wraps correctly).
  always_comb begin : winner_search
    int idx;
    found   = 1'b0;
    win_idx = '0;
    idx     = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NREQ) begin
        idx = idx - NREQ;
      end
      if (!found && req[idx]) begin
        found   = 1'b1;
        win_idx = IDXW'(idx);
      end
    end
  end

  // Next-state and next-output computation for the IDLE/GRANT/HOLD sequence.
  always_comb begin
    state_d     = state_q;
    gnt_d       = '0;
    hold_word_d = hold_word_q;
    valid_d     = valid_q;
    owner_d     = owner_q;
    busy_d      = busy_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    case (state_q)
      IDLE: begin
        // req is only looked at here, so a stale request is never re-granted.
        if (found) begin
          gnt_d       = NREQ'(1) << win_idx;
          hold_word_d = word[win_idx];
          owner_d     = win_idx;
          valid_d     = 1'b1;
          busy_d      = 1'b1;
          ptr_d       = (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;
          state_d     = GRANT;
        end
      end
      GRANT: begin
        if (HOLD_CYCLES > 0) begin
          state_d = HOLD;
          cnt_d   = HOLD_LOAD;
        end else begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      HOLD: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset overrides any in-flight grant or hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      hold_word_q <= '0;
      valid_q     <= 1'b0;
      owner_q     <= '0;
      busy_q      <= 1'b0;
      ptr_q       <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      hold_word_q <= hold_word_d;
      valid_q     <= valid_d;
      owner_q     <= owner_d;
      busy_q      <= busy_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
    end
  end

  assign gnt       = gnt_q;
  assign reg_d     = hold_word_q;
  assign reg_valid = valid_q;
  assign owner     = owner_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_reg_share_arbiter.sv
// Bench for reg_share_arbiter (NREQ=4, WIDTH=8, HOLD_CYCLES=2).
// A busy-countdown model predicts every output each cycle; directed
// scenarios add literal expectations, then a long randomized phase follows.
module tb_reg_share_arbiter;

  localparam int WIDTH = 8;
  localparam int NREQ  = 4;
  localparam int HOLD  = 2;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic [NREQ-1:0]       req = '0;
  logic [NREQ*WIDTH-1:0] wdata = '0;
  logic [NREQ-1:0]       gnt;
  logic [WIDTH-1:0]      reg_d;
  logic                  reg_valid;
  logic [1:0]            owner;
  logic                  busy;

  int n_pass  = 0;
  int n_total = 0;

  // Model state: outputs plus a count of busy cycles still to run.
  logic [NREQ-1:0]  m_gnt   = '0;
  logic [WIDTH-1:0] m_regd  = '0;
  logic             m_valid = 1'b0;
  int               m_owner = 0;
  int               m_ptr   = 0;
  int               m_left  = 0;

  reg_share_arbiter #(
    .WIDTH(WIDTH),
    .NREQ(NREQ),
    .HOLD_CYCLES(HOLD)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .wdata(wdata),
    .gnt(gnt),
    .reg_d(reg_d),
    .reg_valid(reg_valid),
    .owner(owner),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Arbitration is only possible when nothing is busy; a grant makes the
  // arbiter busy for 1 + HOLD cycles.
  task automatic model_step();
    if (reset) begin
      m_gnt = '0; m_regd = '0; m_valid = 1'b0; m_owner = 0; m_ptr = 0; m_left = 0;
    end else if (m_left == 0) begin
      m_gnt = '0;
      if (req != '0) begin
        for (int k = 0; k < NREQ; k++) begin
          int w;
          w = (m_ptr + k) % NREQ;
          if (req[w]) begin
            m_gnt   = '0;
            m_gnt[w] = 1'b1;
            m_regd  = wdata[w*WIDTH +: WIDTH];
            m_owner = w;
            m_valid = 1'b1;
            m_ptr   = (w + 1) % NREQ;
            m_left  = HOLD + 1;
            break;
          end
        end
      end
    end else begin
      m_gnt  = '0;
      m_left = m_left - 1;
    end
  endtask

  // Per-cycle comparison against the model.
  always @(posedge clk) begin
    model_step();
    #1;
    check("m_gnt",   32'(gnt),       32'(m_gnt));
    check("m_reg_d", 32'(reg_d),     32'(m_regd));
    check("m_valid", 32'(reg_valid), 32'(m_valid));
    check("m_owner", 32'(owner),     32'(m_owner));
    check("m_busy",  32'(busy),      32'(m_left > 0));
  end

  // Wait (bounded) for the next grant pulse and check it literally.
  task automatic wait_grant(input string name, input logic [3:0] exp_gnt,
                            input logic [7:0] exp_data, input logic [1:0] exp_owner);
    int n;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (gnt == '0 && n < 20);
    if (gnt == '0) begin
      check({name, "_timeout"}, 32'(gnt), 32'(exp_gnt));
    end else begin
      check({name, "_gnt"},   32'(gnt),   32'(exp_gnt));
      check({name, "_reg_d"}, 32'(reg_d), 32'(exp_data));
      check({name, "_owner"}, 32'(owner), 32'(exp_owner));
    end
  endtask

  initial begin
    // Reset with all requests pending.
    reset = 1'b1;
    req   = 4'b1111;
    wdata = {8'h13, 8'h12, 8'h11, 8'h10};
    repeat (2) @(posedge clk);
    #1;
    check("rst_gnt",   32'(gnt),       32'h0);
    check("rst_reg_d", 32'(reg_d),     32'h0);
    check("rst_valid", 32'(reg_valid), 32'h0);
    check("rst_owner", 32'(owner),     32'h0);
    check("rst_busy",  32'(busy),      32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Constant all-request: 0,1,2,3,0 spaced 4 cycles apart.
    for (int g = 0; g < 5; g++) begin
      repeat ((g == 0) ? 1 : 4) @(posedge clk);
      #1;
      check($sformatf("rr%0d_gnt", g),   32'(gnt),   32'(1 << (g % 4)));
      check($sformatf("rr%0d_reg_d", g), 32'(reg_d), 32'h10 + 32'(g % 4));
    end
    @(negedge clk);
    req = 4'b0000;

    // Grant to 3 wraps ptr to 0; then 1100 must go to 2 before 3.
    @(negedge clk);
    req = 4'b1000;
    wait_grant("wrap3", 4'b1000, 8'h13, 2'd3);
    @(negedge clk);
    req = 4'b1100;
    wait_grant("skip2", 4'b0100, 8'h12, 2'd2);
    @(negedge clk);
    req = 4'b1000;
    wait_grant("then3", 4'b1000, 8'h13, 2'd3);
    @(negedge clk);
    req = 4'b0000;

    // Single request with a distinctive word; busy for exactly 3 cycles.
    repeat (4) @(negedge clk);
    wdata[15:8] = 8'hAA;
    req = 4'b0010;
    wait_grant("single", 4'b0010, 8'hAA, 2'd1);
    check("single_valid", 32'(reg_valid), 32'h1);
    check("single_busy0", 32'(busy), 32'h1);
    @(negedge clk);
    req = 4'b0000;
    @(posedge clk); #1;
    check("single_gnt_off", 32'(gnt),  32'h0);
    check("single_busy1",   32'(busy), 32'h1);
    @(posedge clk); #1;
    check("single_busy2",   32'(busy), 32'h1);
    @(posedge clk); #1;
    check("single_idle",    32'(busy), 32'h0);
    check("single_hold",    32'(reg_d), 32'hAA);

    // Reset one cycle into HOLD; pending 0100 granted afterwards.
    @(negedge clk);
    req = 4'b0001;
    wait_grant("pre_rst", 4'b0001, 8'h10, 2'd0);
    @(negedge clk);
    req = 4'b0100;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("midrst_gnt",   32'(gnt),   32'h0);
    check("midrst_reg_d", 32'(reg_d), 32'h0);
    check("midrst_busy",  32'(busy),  32'h0);
    check("midrst_owner", 32'(owner), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    wait_grant("post_rst", 4'b0100, 8'h12, 2'd2);
    @(negedge clk);
    req = 4'b0000;

    // Randomized requesters obeying the handshake, with rare resets.
    repeat (3000) begin
      @(negedge clk);
      reset = ($urandom_range(0, 199) == 0);
      for (int i = 0; i < NREQ; i++) begin
        if (req[i] && gnt[i]) req[i] = 1'b0;
        else if (!req[i] && $urandom_range(0, 2) == 0) req[i] = 1'b1;
      end
      wdata = $urandom();
    end

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
